// File: rtl/pwm_breathe_ctrl_if.sv
// Write-only register bus between the breathing sequencer and pwm_ip.
// Master drives a one-cycle strobe with address and data in the same cycle.
interface pwm_breathe_ctrl_if;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;

    modport master (
        output bus_we,
        output bus_addr,
        output bus_wdata
    );

    modport slave (
        input bus_we,
        input bus_addr,
        input bus_wdata
    );
endinterface

// File: rtl/pwm_breathe_ctrl.sv
// Breathing-LED sequencer: programs pwm_ip, then ramps DUTY up and down.
// Optional macro PWM_HOLD_EN adds a dwell at the peak and the trough.
module pwm_breathe_ctrl #(
    parameter int PERIOD_VAL = 1000,
    parameter int STEP       = 10,
    parameter int TICK_DIV   = 50000,
    parameter int HOLD_TICKS = 25
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    pwm_breathe_ctrl_if.master  bus,
    output logic                busy,
    output logic [31:0]         duty_cur
);

    localparam logic [31:0] ADDR_CTRL   = 32'h0000_0000;
    localparam logic [31:0] ADDR_PERIOD = 32'h0000_0004;
    localparam logic [31:0] ADDR_DUTY   = 32'h0000_0008;

    localparam logic [31:0] PER = 32'(PERIOD_VAL);
    localparam logic [31:0] STP = 32'(STEP);

    // Counter is wide enough for the longer of a tick and a full dwell.
    localparam int CW = $clog2((HOLD_TICKS + 1) * TICK_DIV + 1);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
`ifdef PWM_HOLD_EN
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS * TICK_DIV - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        WR_PERIOD,
        WR_DUTY0,
        WR_EN,
        WAIT,
        WR_DUTY,
        WR_DIS,
        HOLD
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          up;

    logic [32:0]   sum;
    logic [31:0]   next_duty;
    logic          next_up;

    // Saturating next-duty step; never wraps past 0 or PERIOD_VAL.
    always_comb begin
        sum       = {1'b0, duty_cur} + {1'b0, STP};
        next_duty = duty_cur;
        next_up   = up;
        if (up) begin
            if (sum >= {1'b0, PER}) begin
                next_duty = PER;
                next_up   = 1'b0;
            end else begin
                next_duty = sum[31:0];
            end
        end else if (duty_cur <= STP) begin
            next_duty = '0;
            next_up   = 1'b1;
        end else begin
            next_duty = duty_cur - STP;
        end
    end

    // Sequencer FSM; bus outputs are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            up            <= 1'b1;
            busy          <= 1'b0;
            duty_cur      <= '0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
        end else begin
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state         <= WR_PERIOD;
                        busy          <= 1'b1;
                        bus.bus_we    <= 1'b1;
                        bus.bus_addr  <= ADDR_PERIOD;
                        bus.bus_wdata <= PER;
                    end
                end
                WR_PERIOD: begin
                    if (!enable) begin
                        state         <= WR_DIS;
                        bus.bus_we    <= 1'b1;
                        bus.bus_addr  <= ADDR_CTRL;
                        bus.bus_wdata <= '0;
                    end else begin
                        state         <= WR_DUTY0;
                        duty_cur      <= '0;
                        up            <= 1'b1;
                        bus.bus_we    <= 1'b1;
                        bus.bus_addr  <= ADDR_DUTY;
                        bus.bus_wdata <= '0;
                    end
                end
                WR_DUTY0: begin
                    bus.bus_we   <= 1'b1;
                    bus.bus_addr <= ADDR_CTRL;
                    if (!enable) begin
                        state         <= WR_DIS;
                        bus.bus_wdata <= '0;
                    end else begin
                        state         <= WR_EN;
                        bus.bus_wdata <= 32'd1;
                    end
                end
                WR_EN: begin
                    cnt <= '0;
                    if (!enable) begin
                        state         <= WR_DIS;
                        bus.bus_we    <= 1'b1;
                        bus.bus_addr  <= ADDR_CTRL;
                        bus.bus_wdata <= '0;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!enable) begin
                        state         <= WR_DIS;
                        bus.bus_we    <= 1'b1;
                        bus.bus_addr  <= ADDR_CTRL;
                        bus.bus_wdata <= '0;
                    end else if (cnt == TICK_LAST) begin
                        state         <= WR_DUTY;
                        duty_cur      <= next_duty;
                        up            <= next_up;
                        bus.bus_we    <= 1'b1;
                        bus.bus_addr  <= ADDR_DUTY;
                        bus.bus_wdata <= next_duty;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WR_DUTY: begin
                    cnt <= '0;
                    if (!enable) begin
                        state         <= WR_DIS;
                        bus.bus_we    <= 1'b1;
                        bus.bus_addr  <= ADDR_CTRL;
                        bus.bus_wdata <= '0;
                    end else begin
`ifdef PWM_HOLD_EN
                        if (duty_cur == PER || duty_cur == '0)
                            state <= HOLD;
                        else
                            state <= WAIT;
`else
                        state <= WAIT;
`endif
                    end
                end
`ifdef PWM_HOLD_EN
                HOLD: begin
                    if (!enable) begin
                        state         <= WR_DIS;
                        bus.bus_we    <= 1'b1;
                        bus.bus_addr  <= ADDR_CTRL;
                        bus.bus_wdata <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        state <= WAIT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                WR_DIS: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_breathe_ctrl.sv
// Directed bench for pwm_breathe_ctrl with PERIOD_VAL=20, TICK_DIV=4.
// Two instances: STEP=5 and STEP=6; hold timing follows PWM_HOLD_EN.
module tb_pwm_breathe_ctrl;

    localparam int PER  = 20;
    localparam int TDIV = 4;
    localparam int HT   = 2;
`ifdef PWM_HOLD_EN
    localparam int HOLD_GAP = HT * TDIV;
`else
    localparam int HOLD_GAP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en0 = 1'b0;
    logic        en1 = 1'b0;
    logic        busy0;
    logic        busy1;
    logic [31:0] duty0;
    logic [31:0] duty1;

    int checks = 0;
    int errors = 0;

    int seq_a[9] = '{5, 10, 15, 20, 15, 10, 5, 0, 5};
    int seq_b[9] = '{6, 12, 18, 20, 14, 8, 2, 0, 6};

    pwm_breathe_ctrl_if b0 ();
    pwm_breathe_ctrl_if b1 ();

    pwm_breathe_ctrl #(
        .PERIOD_VAL (PER),
        .STEP       (5),
        .TICK_DIV   (TDIV),
        .HOLD_TICKS (HT)
    ) u0 (
        .clk      (clk),
        .rst      (rst),
        .enable   (en0),
        .bus      (b0),
        .busy     (busy0),
        .duty_cur (duty0)
    );

    pwm_breathe_ctrl #(
        .PERIOD_VAL (PER),
        .STEP       (6),
        .TICK_DIV   (TDIV),
        .HOLD_TICKS (HT)
    ) u1 (
        .clk      (clk),
        .rst      (rst),
        .enable   (en1),
        .bus      (b1),
        .busy     (busy1),
        .duty_cur (duty1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic get_we(input int sel);
        return (sel == 0) ? b0.bus_we : b1.bus_we;
    endfunction

    function automatic logic [31:0] get_addr(input int sel);
        return (sel == 0) ? b0.bus_addr : b1.bus_addr;
    endfunction

    function automatic logic [31:0] get_wdata(input int sel);
        return (sel == 0) ? b0.bus_wdata : b1.bus_wdata;
    endfunction

    function automatic logic [31:0] get_duty(input int sel);
        return (sel == 0) ? duty0 : duty1;
    endfunction

    task automatic expect_write(input int sel, input string tag,
                                input logic [31:0] a,
                                input logic [31:0] d);
        @(negedge clk);
        check({tag, " we"}, 32'(get_we(sel)), 32'd1);
        check({tag, " addr"}, get_addr(sel), a);
        check({tag, " data"}, get_wdata(sel), d);
    endtask

    task automatic next_write(input int sel,
                              output logic [31:0] a,
                              output logic [31:0] d,
                              output logic [31:0] dc,
                              output int gap);
        a   = '0;
        d   = '0;
        dc  = '0;
        gap = 0;
        repeat (40) begin
            @(negedge clk);
            gap++;
            if (get_we(sel)) begin
                a  = get_addr(sel);
                d  = get_wdata(sel);
                dc = get_duty(sel);
                return;
            end
        end
        gap = -1;
    endtask

    task automatic run_ramp(input int sel, input string tag,
                            input int seq[9]);
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] dc;
        int gap;
        int prev;
        int exp_gap;
        prev = -1;
        for (int i = 0; i < 9; i++) begin
            next_write(sel, a, d, dc, gap);
            exp_gap = (prev == PER || prev == 0) ? 5 + HOLD_GAP : 5;
            check($sformatf("%s[%0d] gap", tag, i), gap, exp_gap);
            check($sformatf("%s[%0d] addr", tag, i), a, 32'h8);
            check($sformatf("%s[%0d] data", tag, i), d, seq[i]);
            check($sformatf("%s[%0d] duty_cur", tag, i), dc, seq[i]);
            prev = seq[i];
        end
    endtask

    task automatic idle_check(input int sel, input string tag);
        int bad;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (get_we(sel) || get_addr(sel) != 0 || get_wdata(sel) != 0)
                bad++;
        end
        check(tag, bad, 0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] dc;
        int gap;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst we", 32'(b0.bus_we), 0);
        check("rst addr", b0.bus_addr, 0);
        check("rst wdata", b0.bus_wdata, 0);
        check("rst busy", 32'(busy0), 0);
        check("rst duty", duty0, 0);
        check("rst busy1", 32'(busy1), 0);
        rst = 1'b0;

        @(negedge clk);
        en0 = 1'b1;
        expect_write(0, "setup period", 32'h4, 32'd20);
        check("setup busy", 32'(busy0), 1);
        expect_write(0, "setup duty0", 32'h8, 32'd0);
        expect_write(0, "setup en", 32'h0, 32'd1);

        run_ramp(0, "ramp5", seq_a);

        next_write(0, a, d, dc, gap);
        check("pre-dis gap", gap, 5);
        check("pre-dis data", d, 10);
        @(negedge clk);
        en0 = 1'b0;
        expect_write(0, "wait dis", 32'h0, 32'd0);
        @(negedge clk);
        check("dis we", 32'(b0.bus_we), 0);
        check("dis busy", 32'(busy0), 0);
        check("dis duty_cur", duty0, 10);
        idle_check(0, "dis quiet");

        @(negedge clk);
        en0 = 1'b1;
        expect_write(0, "abort period", 32'h4, 32'd20);
        en0 = 1'b0;
        expect_write(0, "abort dis", 32'h0, 32'd0);
        @(negedge clk);
        check("abort busy", 32'(busy0), 0);
        idle_check(0, "abort quiet");

        @(negedge clk);
        en1 = 1'b1;
        expect_write(1, "s6 period", 32'h4, 32'd20);
        expect_write(1, "s6 duty0", 32'h8, 32'd0);
        expect_write(1, "s6 en", 32'h0, 32'd1);
        run_ramp(1, "ramp6", seq_b);

        repeat (2) @(negedge clk);
        rst = 1'b1;
        en1 = 1'b0;
        #1;
        check("async we", 32'(b1.bus_we), 0);
        check("async busy", 32'(busy1), 0);
        check("async duty", duty1, 0);
        @(negedge clk);
        rst = 1'b0;
        idle_check(1, "post-rst quiet");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
